// File: rtl/regfile.sv
// regfile: architectural register state for the single-cycle datapath.
// 32 integer GPRs (GPR0 hardwired to zero), 32 single-precision FPRs that
// pair up as doubles on even/odd boundaries, and the FP condition flag.
// Reads are combinational; writes land on the rising clock edge.
module regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  // integer register file
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  input  logic                  reg_write,
  input  logic [4:0]            rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  link,
  input  logic [DATA_W-1:0]     pc_8_in,
  // floating-point register file
  input  logic [4:0]            fs1_addr,
  input  logic [4:0]            fs2_addr,
  output logic [DATA_W-1:0]     fs1_data,
  output logic [DATA_W-1:0]     fs2_data,
  output logic [2*DATA_W-1:0]   fs1_dbl,
  output logic [2*DATA_W-1:0]   fs2_dbl,
  input  logic                  fp_write,
  input  logic                  fp_double,
  input  logic [4:0]            fd_addr,
  input  logic [2*DATA_W-1:0]   fd_data,
  // FP condition flag
  input  logic                  fp_cond_write,
  input  logic                  fp_cond_in,
  output logic                  fp_cond
);

  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] fpr [32];

  // Aligned pair indices for double reads: even register is the high word.
  logic [4:0] fs1_hi, fs1_lo, fs2_hi, fs2_lo;

  // GPR write ports. Link and reg_write are separate ports; when both target
  // the link register the link value takes priority. Index 0 is never written.
  // The per-index compare leaves every register untouched if an address is
  // unknown, so an X address cannot corrupt unrelated state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (link && (LINK_REG == i)) begin
          gpr[i] <= pc_8_in;
        end else if (reg_write && (rd_addr == 5'(i))) begin
          gpr[i] <= rd_data;
        end
      end
    end
  end

  // FPR write port. A double write updates the aligned even/odd pair (odd
  // fd_addr is aligned down); a single write updates one register from the
  // low half of fd_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        fpr[i] <= '0;
      end
    end else if (fp_write) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (fp_double) begin
          if (fd_addr[4:1] == 4'(i >> 1)) begin
            if (i[0]) begin
              fpr[i] <= fd_data[DATA_W-1:0];
            end else begin
              fpr[i] <= fd_data[2*DATA_W-1:DATA_W];
            end
          end
        end else if (fd_addr == 5'(i)) begin
          fpr[i] <= fd_data[DATA_W-1:0];
        end
      end
    end
  end

  // FP condition flag: registered compare result, holds when not written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fp_cond <= 1'b0;
    end else if (fp_cond_write) begin
      fp_cond <= fp_cond_in;
    end
  end

  // Combinational read ports; GPR0 is forced to zero on read.
  always_comb begin
    fs1_hi   = {fs1_addr[4:1], 1'b0};
    fs1_lo   = {fs1_addr[4:1], 1'b1};
    fs2_hi   = {fs2_addr[4:1], 1'b0};
    fs2_lo   = {fs2_addr[4:1], 1'b1};
    rs1_data = (rs1_addr == 5'd0) ? '0 : gpr[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? '0 : gpr[rs2_addr];
    fs1_data = fpr[fs1_addr];
    fs2_data = fpr[fs2_addr];
    fs1_dbl  = {fpr[fs1_hi], fpr[fs1_lo]};
    fs2_dbl  = {fpr[fs2_hi], fpr[fs2_lo]};
  end

  // Flag writes whose address contains unknown bits (simulation only).
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      if (reg_write === 1'b1)
        a_rd_known: assert (!$isunknown(rd_addr))
          else $error("regfile: reg_write with unknown rd_addr %b", rd_addr);
      if (fp_write === 1'b1)
        a_fd_known: assert (!$isunknown(fd_addr))
          else $error("regfile: fp_write with unknown fd_addr %b", fd_addr);
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed checks of the regfile with hand-computed expectations.
module tb_regfile;

  logic        clock;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data, pc_8_in;
  logic        reg_write, link;
  logic [4:0]  fs1_addr, fs2_addr, fd_addr;
  logic [31:0] fs1_data, fs2_data;
  logic [63:0] fs1_dbl, fs2_dbl, fd_data;
  logic        fp_write, fp_double, fp_cond_write, fp_cond_in, fp_cond;

  int errors = 0;
  int checks = 0;

  regfile #(.DATA_W(32), .LINK_REG(31)) dut (
    .clock         (clock),
    .reset         (reset),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .reg_write     (reg_write),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .link          (link),
    .pc_8_in       (pc_8_in),
    .fs1_addr      (fs1_addr),
    .fs2_addr      (fs2_addr),
    .fs1_data      (fs1_data),
    .fs2_data      (fs2_data),
    .fs1_dbl       (fs1_dbl),
    .fs2_dbl       (fs2_dbl),
    .fp_write      (fp_write),
    .fp_double     (fp_double),
    .fd_addr       (fd_addr),
    .fd_data       (fd_data),
    .fp_cond_write (fp_cond_write),
    .fp_cond_in    (fp_cond_in),
    .fp_cond       (fp_cond)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reg_write     = 1'b0;
    link          = 1'b0;
    fp_write      = 1'b0;
    fp_double     = 1'b0;
    fp_cond_write = 1'b0;
    fp_cond_in    = 1'b0;
    rd_addr       = '0;
    rd_data       = '0;
    pc_8_in       = '0;
    fd_addr       = '0;
    fd_data       = '0;
  endtask

  initial begin
    idle();
    reset    = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    fs1_addr = 5'd3;
    fs2_addr = 5'd8;
    #3;
    check("reset_rs1", 64'(rs1_data), 64'h0);
    check("reset_fs1", 64'(fs1_data), 64'h0);
    check("reset_fpcond", 64'(fp_cond), 64'h0);

    // Preload GPR5 and FPR3 in the same cycle.
    @(negedge clock);
    reset     = 1'b1;
    reg_write = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    fp_write  = 1'b1; fd_addr = 5'd3; fd_data = 64'h0000_0000_3F80_0000;
    tick();
    idle();
    check("preload_gpr5", 64'(rs1_data), 64'hDEADBEEF);
    check("preload_fpr3", 64'(fs1_data), 64'h3F800000);

    // Reset mid-cycle clears outputs without a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check("async_clr_gpr5", 64'(rs1_data), 64'h0);
    check("async_clr_fpr3", 64'(fs1_data), 64'h0);

    // Write presented at an edge while reset is low is discarded.
    reg_write = 1'b1; rd_addr = 5'd6; rd_data = 32'h66666666;
    tick();
    idle();
    @(negedge clock);
    reset    = 1'b1;
    rs1_addr = 5'd6;
    tick();
    check("wr_in_reset_dropped", 64'(rs1_data), 64'h0);

    // GPR0 write is dropped.
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234;
    rs1_addr  = 5'd0;
    tick();
    idle();
    check("gpr0_zero", 64'(rs1_data), 64'h0);

    // No same-cycle bypass: old value during the write cycle.
    reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5;
    rs1_addr  = 5'd7;
    #1;
    check("gpr7_old", 64'(rs1_data), 64'h0);
    tick();
    idle();
    check("gpr7_new", 64'(rs1_data), 64'hA5A5A5A5);

    // Link alone.
    link = 1'b1; pc_8_in = 32'h00000108;
    tick();
    idle();
    check("link_gpr31", 64'(rs2_data), 64'h108);

    // Link and reg_write to the link register: link wins.
    link = 1'b1; pc_8_in = 32'h00000108;
    reg_write = 1'b1; rd_addr = 5'd31; rd_data = 32'h55;
    tick();
    idle();
    check("link_wins", 64'(rs2_data), 64'h108);

    // Link plus reg_write elsewhere, with an FP double write in the same cycle.
    link = 1'b1; pc_8_in = 32'h00000200;
    reg_write = 1'b1; rd_addr = 5'd4; rd_data = 32'h55;
    fp_write = 1'b1; fp_double = 1'b1; fd_addr = 5'd9;
    fd_data = 64'h400921FB_54442D18;
    rs1_addr = 5'd4;
    fs1_addr = 5'd9;
    tick();
    idle();
    check("dual_port_gpr31", 64'(rs2_data), 64'h200);
    check("dual_port_gpr4", 64'(rs1_data), 64'h55);
    check("dbl_fpr9", 64'(fs1_data), 64'h54442D18);
    check("dbl_fpr8", 64'(fs2_data), 64'h400921FB);
    check("dbl_read_odd", fs1_dbl, 64'h400921FB_54442D18);
    check("dbl_read_even", fs2_dbl, 64'h400921FB_54442D18);

    // Single write ignores the upper half and leaves the pair partner alone.
    fp_write = 1'b1; fp_double = 1'b0; fd_addr = 5'd9;
    fd_data = 64'hFFFFFFFF_00000001;
    tick();
    idle();
    check("single_fpr9", 64'(fs1_data), 64'h1);
    check("single_fpr8_kept", 64'(fs2_data), 64'h400921FB);
    check("single_dbl", fs1_dbl, 64'h400921FB_00000001);

    // FPR0 is an ordinary register.
    fp_write = 1'b1; fd_addr = 5'd0; fd_data = 64'h0000_0000_CAFEF00D;
    fs2_addr = 5'd0;
    tick();
    idle();
    check("fpr0_writable", 64'(fs2_data), 64'hCAFEF00D);

    // fp_cond: registered load, then hold.
    fp_cond_write = 1'b1; fp_cond_in = 1'b1;
    #1;
    check("fpcond_before_edge", 64'(fp_cond), 64'h0);
    tick();
    idle();
    check("fpcond_set", 64'(fp_cond), 64'h1);
    fp_cond_write = 1'b0; fp_cond_in = 1'b0;
    tick();
    check("fpcond_hold", 64'(fp_cond), 64'h1);

    // Async reset clears the flag and all state immediately.
    #2;
    reset = 1'b0;
    #1;
    check("fpcond_reset", 64'(fp_cond), 64'h0);
    check("reset_gpr31", 64'(rs2_data), 64'h0);
    check("reset_dbl", fs1_dbl, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
